// File: rtl/z80_bus_router.sv
// Z80 data-bus steering: memory/IO strobe decode with programmable wait states,
// per-channel IO select, and IM2 interrupt-acknowledge vectoring.
module z80_bus_router #(
  parameter int unsigned    DW         = 8,
  parameter int unsigned    AW         = 16,
  parameter int unsigned    SEL_W      = 2,
  parameter int unsigned    IO_SEL_LSB = 6,
  parameter int unsigned    MEM_WAIT   = 0,
  parameter int unsigned    IO_WAIT    = 2,
  parameter logic [DW-1:0]  VEC_BASE   = 8'hE0,
  localparam int unsigned   NUM_IO     = 2**SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mreq,
  input  logic                 ioreq,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 m1,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        cpu_dout,
  output logic [DW-1:0]        cpu_din,
  output logic                 cpu_din_oe,
  output logic                 wait_n,
  input  logic [DW-1:0]        mem_din,
  output logic [DW-1:0]        mem_dout,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [NUM_IO*DW-1:0] io_din,
  output logic [DW-1:0]        io_dout,
  output logic [NUM_IO-1:0]    io_sel,
  output logic                 io_re,
  output logic                 io_we,
  output logic                 io_active,
  input  logic [NUM_IO-1:0]    irq_req,
  output logic [NUM_IO-1:0]    irq_ack,
  output logic                 int_n
);

  if (MEM_WAIT > 15 || IO_WAIT > 15) begin : g_bad_wait
    $error("z80_bus_router: MEM_WAIT and IO_WAIT must be within 0..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    IO,
    INTA,
    CAPT,
    HOLD
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] ch;
  logic             is_read;
  logic             is_io;
  logic [SEL_W-1:0] irq_idx;
  logic             irq_any;

  logic [SEL_W-1:0] ch_c;
  logic [SEL_W-1:0] irq_idx_c;
  logic [DW-1:0]    vec_c;
  logic [DW-1:0]    io_rdata_c;
  logic             req_gone_c;
  logic             addr_unused;

  assign addr_unused = ^addr;
  assign ch_c        = addr[IO_SEL_LSB +: SEL_W];
  assign vec_c       = VEC_BASE | (DW'(irq_idx) << 1);
  assign io_rdata_c  = io_din[int'(ch)*DW +: DW];
  assign req_gone_c  = is_io ? ioreq : mreq;

  // Lowest set bit wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    irq_idx_c = '0;
    for (int unsigned i = NUM_IO; i > 0; i--) begin
      if (irq_req[i-1]) irq_idx_c = SEL_W'(i-1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ch         <= '0;
      is_read    <= 1'b0;
      is_io      <= 1'b0;
      irq_idx    <= '0;
      irq_any    <= 1'b0;
      cpu_din    <= '0;
      cpu_din_oe <= 1'b0;
      wait_n     <= 1'b1;
      int_n      <= 1'b1;
      mem_dout   <= '0;
      io_dout    <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      io_re      <= 1'b0;
      io_we      <= 1'b0;
      io_sel     <= '0;
      io_active  <= 1'b0;
      irq_ack    <= '0;
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      io_re   <= 1'b0;
      io_we   <= 1'b0;
      irq_ack <= '0;
      int_n   <= ~|irq_req;

      case (state)
        IDLE: begin
          if (!ioreq && !m1) begin
            state   <= INTA;
            irq_idx <= irq_idx_c;
            irq_any <= |irq_req;
          end else if (!ioreq && (rd ^ wr)) begin
            state     <= IO;
            is_io     <= 1'b1;
            is_read   <= !rd;
            ch        <= ch_c;
            cnt       <= 4'(IO_WAIT);
            io_sel    <= NUM_IO'(1) << ch_c;
            io_active <= 1'b1;
            // Reads hold the CPU until data is captured; writes only for the count.
            wait_n    <= rd && (IO_WAIT == 0);
          end else if (!mreq && (rd ^ wr)) begin
            state   <= MEM;
            is_io   <= 1'b0;
            is_read <= !rd;
            cnt     <= 4'(MEM_WAIT);
            wait_n  <= rd && (MEM_WAIT == 0);
          end
        end

        MEM, IO: begin
          if (req_gone_c) begin
            state     <= IDLE;
            wait_n    <= 1'b1;
            io_sel    <= '0;
            io_active <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            wait_n <= !is_read && (cnt == 4'd1);
          end else if (is_read) begin
            state  <= CAPT;
            wait_n <= 1'b0;
            if (is_io) io_re  <= 1'b1;
            else       mem_re <= 1'b1;
          end else begin
            state  <= HOLD;
            wait_n <= 1'b1;
            if (is_io) begin
              io_dout <= cpu_dout;
              io_we   <= 1'b1;
            end else begin
              mem_dout <= cpu_dout;
              mem_we   <= 1'b1;
            end
          end
        end

        CAPT: begin
          state      <= HOLD;
          cpu_din    <= is_io ? io_rdata_c : mem_din;
          cpu_din_oe <= 1'b1;
          wait_n     <= 1'b1;
        end

        INTA: begin
          state      <= HOLD;
          cpu_din_oe <= 1'b1;
          if (irq_any) begin
            cpu_din          <= vec_c;
            irq_ack[irq_idx] <= 1'b1;
          end else begin
            cpu_din <= '1;
          end
        end

        HOLD: begin
          if (mreq && ioreq) begin
            state      <= IDLE;
            cpu_din_oe <= 1'b0;
            io_sel     <= '0;
            io_active  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_router.sv
// Directed bench for z80_bus_router: per-cycle expectations built from
// transaction timelines, checked by one compare process, plus literal pins.
module tb_z80_bus_router;

  localparam int MEM_WAIT = 0;
  localparam int IO_WAIT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mreq = 1'b1, ioreq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_din_oe, wait_n;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic        mem_re, mem_we;
  logic [31:0] io_din = {8'hD3, 8'hD2, 8'hB1, 8'hA0};
  logic [7:0]  io_dout;
  logic [3:0]  io_sel;
  logic        io_re, io_we, io_active;
  logic [3:0]  irq_req = '0;
  logic [3:0]  irq_ack;
  logic        int_n;

  z80_bus_router #(
    .DW(8), .AW(16), .SEL_W(2), .IO_SEL_LSB(6),
    .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .VEC_BASE(8'hE0)
  ) dut (
    .clk(clk), .reset(reset), .mreq(mreq), .ioreq(ioreq), .rd(rd), .wr(wr), .m1(m1),
    .addr(addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_din_oe(cpu_din_oe),
    .wait_n(wait_n), .mem_din(mem_din), .mem_dout(mem_dout), .mem_re(mem_re),
    .mem_we(mem_we), .io_din(io_din), .io_dout(io_dout), .io_sel(io_sel),
    .io_re(io_re), .io_we(io_we), .io_active(io_active), .irq_req(irq_req),
    .irq_ack(irq_ack), .int_n(int_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wait_n;
    logic [7:0] cpu_din;
    logic       oe;
    logic       mem_re, mem_we, io_re, io_we;
    logic [3:0] io_sel;
    logic       io_active;
    logic [3:0] irq_ack;
    logic [7:0] mem_dout, io_dout;
    logic       int_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural state the model carries between transactions.
  logic [7:0] m_cpu_din = '0, m_mem_dout = '0, m_io_dout = '0;
  logic       m_oe = 1'b0;
  logic [3:0] m_io_sel = '0;

  // Event tallies observed on the DUT, used by the literal pins.
  int         cnt_mem_re = 0, cnt_io_re = 0, cnt_io_we = 0, cnt_ack = 0, cnt_wait_low = 0;
  logic [3:0] last_ack = '0, last_sel = '0;

  always @(posedge clk) begin
    #1;
    if (mem_re) cnt_mem_re++;
    if (io_re) cnt_io_re++;
    if (io_we) cnt_io_we++;
    if (irq_ack != 0) begin cnt_ack++; last_ack = irq_ack; end
    if (!wait_n) cnt_wait_low++;
    if (io_active) last_sel = io_sel;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e.wait_n = 1'b1; e.cpu_din = m_cpu_din; e.oe = m_oe;
    e.mem_re = 1'b0; e.mem_we = 1'b0; e.io_re = 1'b0; e.io_we = 1'b0;
    e.io_sel = m_io_sel; e.io_active = |m_io_sel; e.irq_ack = '0;
    e.mem_dout = m_mem_dout; e.io_dout = m_io_dout; e.int_n = ~|irq_req;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : cmp
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wait_n", wait_n, e.wait_n);
        chk("cpu_din", cpu_din, e.cpu_din);
        chk("cpu_din_oe", cpu_din_oe, e.oe);
        chk("mem_re", mem_re, e.mem_re);
        chk("mem_we", mem_we, e.mem_we);
        chk("io_re", io_re, e.io_re);
        chk("io_we", io_we, e.io_we);
        chk("io_sel", io_sel, e.io_sel);
        chk("io_active", io_active, e.io_active);
        chk("irq_ack", irq_ack, e.irq_ack);
        chk("mem_dout", mem_dout, e.mem_dout);
        chk("io_dout", io_dout, e.io_dout);
        chk("int_n", int_n, e.int_n);
      end
    end
  end

  // One CPU memory/IO cycle. Cycle 0 follows the decode edge, cycles 1..n are
  // waits, cycle n+1 carries the strobe, cycle n+2 the read data.
  task automatic access(input bit is_io, input bit is_rd, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rdata,
                        input int abort_at, input bit also_mreq);
    int n;
    exp_t e;
    n = is_io ? IO_WAIT : MEM_WAIT;
    addr = a; cpu_dout = wd;
    if (is_io) begin ioreq = 1'b0; mreq = also_mreq ? 1'b0 : 1'b1; end
    else mreq = 1'b0;
    rd = !is_rd; wr = is_rd;
    m_io_sel = is_io ? 4'(1 << a[7:6]) : 4'b0;
    e = base(); e.wait_n = is_rd ? 1'b0 : (n == 0); step(e);
    for (int k = 1; k <= n + 1; k++) begin
      if (k == abort_at) begin
        mreq = 1'b1; ioreq = 1'b1; m_io_sel = '0;
        e = base(); step(e);
        rd = 1'b1; wr = 1'b1;
        e = base(); step(e);
        return;
      end
      if (k == n + 1 && !is_rd) begin
        if (is_io) m_io_dout = wd; else m_mem_dout = wd;
      end
      e = base();
      if (k <= n) e.wait_n = is_rd ? 1'b0 : (k == n);
      else if (is_rd) begin
        e.wait_n = 1'b0;
        if (is_io) e.io_re = 1'b1; else e.mem_re = 1'b1;
      end else begin
        if (is_io) e.io_we = 1'b1; else e.mem_we = 1'b1;
      end
      step(e);
    end
    if (is_rd) begin
      m_cpu_din = rdata; m_oe = 1'b1;
      e = base(); step(e);
    end
    mreq = 1'b1; ioreq = 1'b1; rd = 1'b1; wr = 1'b1;
    m_oe = 1'b0; m_io_sel = '0;
    e = base(); step(e);
  endtask

  task automatic inta(input logic [3:0] r);
    logic [3:0] onehot;
    int idx;
    exp_t e;
    irq_req = r;
    e = base(); step(e);
    m1 = 1'b0; ioreq = 1'b0;
    e = base(); step(e);
    onehot = r & (~r + 4'd1);
    idx = (onehot == 0) ? 0 : $clog2(onehot);
    m_cpu_din = (r == 0) ? 8'hFF : (8'hE0 | 8'(idx << 1));
    m_oe = 1'b1;
    e = base(); e.irq_ack = onehot; step(e);
    m1 = 1'b1; ioreq = 1'b1; m_oe = 1'b0;
    e = base(); step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2;
    exp_t e;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cpu_din", cpu_din, 8'h00);
    chk("rst_oe", cpu_din_oe, 1'b0);
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_io_sel", io_sel, 4'b0000);
    chk("rst_io_active", io_active, 1'b0);
    reset = 1'b0;
    repeat (2) begin e = base(); step(e); end

    // Memory read, no wait states.
    mem_din = 8'h5A; s0 = cnt_mem_re;
    access(1'b0, 1'b1, 16'h1234, 8'h00, 8'h5A, 0, 1'b0);
    chk("memrd_pin_data", cpu_din, 8'h5A);
    chk("memrd_pin_oe_released", cpu_din_oe, 1'b0);
    chk("memrd_pin_re_count", cnt_mem_re - s0, 1);

    // Memory write.
    access(1'b0, 1'b0, 16'h8001, 8'h3C, 8'h00, 0, 1'b0);
    chk("memwr_pin_dout", mem_dout, 8'h3C);

    // IO write to channel 3 with two wait states.
    s0 = cnt_io_we; s1 = cnt_wait_low;
    access(1'b1, 1'b0, 16'h00C3, 8'h99, 8'h00, 0, 1'b0);
    chk("iowr_pin_sel", last_sel, 4'b1000);
    chk("iowr_pin_dout", io_dout, 8'h99);
    chk("iowr_pin_we_count", cnt_io_we - s0, 1);
    chk("iowr_pin_wait_cycles", cnt_wait_low - s1, 2);

    // Reset asserted in the middle of an IO write wait.
    s0 = cnt_io_we;
    addr = 16'h00C3; cpu_dout = 8'h77; ioreq = 1'b0; wr = 1'b0;
    m_io_sel = 4'b1000;
    e = base(); e.wait_n = 1'b0; step(e);
    e = base(); e.wait_n = 1'b0; step(e);
    #2 reset = 1'b1;
    #1;
    chk("midrst_io_sel", io_sel, 4'b0000);
    chk("midrst_io_active", io_active, 1'b0);
    chk("midrst_wait_n", wait_n, 1'b1);
    chk("midrst_io_dout", io_dout, 8'h00);
    chk("midrst_cpu_din", cpu_din, 8'h00);
    chk("midrst_io_we", io_we, 1'b0);
    ioreq = 1'b1; wr = 1'b1;
    m_cpu_din = '0; m_oe = 1'b0; m_io_sel = '0; m_mem_dout = '0; m_io_dout = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) begin e = base(); step(e); end
    chk("midrst_no_we", cnt_io_we - s0, 0);

    // Interrupt acknowledge: pending 0110, then nothing pending.
    s0 = cnt_ack;
    inta(4'b0110);
    chk("inta_pin_vec", cpu_din, 8'hE2);
    chk("inta_pin_ack", last_ack, 4'b0010);
    inta(4'b0000);
    chk("inta_none_pin_vec", cpu_din, 8'hFF);
    chk("inta_none_pin_acks", cnt_ack - s0, 1);
    inta(4'b1000);
    chk("inta_low_pin_vec", cpu_din, 8'hE6);
    irq_req = '0;
    e = base(); step(e);

    // IO read aborted after one wait cycle.
    s0 = cnt_io_re;
    access(1'b1, 1'b1, 16'h0000, 8'h00, 8'h00, 2, 1'b0);
    chk("abort_pin_no_re", cnt_io_re - s0, 0);
    chk("abort_pin_wait_n", wait_n, 1'b1);

    // Both rd and wr low, then a refresh cycle: nothing may happen.
    s0 = cnt_mem_re; s1 = cnt_io_re; s2 = cnt_wait_low;
    mreq = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (2) begin e = base(); step(e); end
    rd = 1'b1; wr = 1'b1;
    repeat (2) begin e = base(); step(e); end
    mreq = 1'b1;
    e = base(); step(e);
    chk("ignore_pin_no_strobe", (cnt_mem_re - s0) + (cnt_io_re - s1), 0);
    chk("ignore_pin_no_wait", cnt_wait_low - s2, 0);

    // IO read with mreq also low: IO path wins; channel 1 data.
    access(1'b1, 1'b1, 16'h0040, 8'h00, 8'hB1, 0, 1'b1);
    chk("both_req_pin_data", cpu_din, 8'hB1);

    // Plain IO read on channel 2 and a memory read afterwards.
    access(1'b1, 1'b1, 16'h0080, 8'h00, 8'hD2, 0, 1'b0);
    mem_din = 8'hA5;
    access(1'b0, 1'b1, 16'h4000, 8'h00, 8'hA5, 0, 1'b0);
    chk("final_pin_data", cpu_din, 8'hA5);

    repeat (2) begin e = base(); step(e); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
